compute_s: RTL and testbench

Second-pass IDCT stage of the decoder's block pipeline. On a start pulse it computes one 8x8 pixel block S = Cᵀ·T from the intermediate matrix T held in a dual-port RAM. It clips each result to 8 bits and writes the 64 bytes into the S dual-port RAM. The downstream SRAM write-back stage then copies that RAM into the Y/U/V regions of external SRAM. A single multiplier and a single accumulator do the work, one output element at a time.

---
 rtl/compute_s_if.sv | 34 +++
 rtl/compute_s.sv | 148 ++++++++++++++
 tb/tb_compute_s.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/compute_s_if.sv
// Start/done handshake plus the T RAM read port and the S RAM write port
// used by the second-pass IDCT stage.
interface compute_s_if #(
    parameter int DATA_W = 32
);
    logic              CS_start;
    logic              CS_done;
    logic [5:0]        T_address;
    logic [DATA_W-1:0] T_read_data;
    logic [8:0]        S_address;
    logic [7:0]        S_write_data;
    logic              S_we;

    // master is the compute stage itself; slave is the surrounding pipeline and RAMs
    modport master (
        input  CS_start,
        input  T_read_data,
        output CS_done,
        output T_address,
        output S_address,
        output S_write_data,
        output S_we
    );

    modport slave (
        output CS_start,
        output T_read_data,
        input  CS_done,
        input  T_address,
        input  S_address,
        input  S_write_data,
        input  S_we
    );
endinterface

// File: rtl/compute_s.sv
// Second-pass IDCT: S = C^T * T for one 8x8 block, one multiply-accumulate per
// cycle, each result clipped to a byte and written to the S RAM.
module compute_s #(
    parameter int         DATA_W = 32,
    parameter int         COEF_W = 13,
    parameter int         ACC_W  = 48,
    parameter logic [8:0] S_BASE = 9'd0
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    compute_s_if.master bus
);

    localparam int PROD_W = DATA_W + COEF_W;

    typedef enum logic [2:0] {
        S_CS_IDLE,
        S_CS_READ,
        S_CS_FLUSH,
        S_CS_WRITE,
        S_CS_DONE
    } cs_state_t;

    cs_state_t state, state_n;

    logic [2:0]              x;
    logic [2:0]              y;
    logic [2:0]              u;
    logic signed [ACC_W-1:0] acc;

    logic signed [COEF_W-1:0] coef_c;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    // c(u,x) = sign(cos(m*pi/16)) * M[fold(m)], m = (2x+1)u mod 32; m never hits 0, 8, 16 or 24
    function automatic logic signed [COEF_W-1:0] coef(input logic [2:0] cu, input logic [2:0] cx);
        logic [4:0] m;
        logic [3:0] k;
        logic       neg;
        int         mag;
        m   = {1'b0, cx, 1'b1} * {2'b00, cu};
        k   = m[3:0];
        if (k > 4'd8)
            k = 4'd0 - k;
        neg = (m > 5'd8) && (m < 5'd24);
        case (k)
            4'd1:    mag = 2008;
            4'd2:    mag = 1892;
            4'd3:    mag = 1702;
            4'd4:    mag = 1448;
            4'd5:    mag = 1137;
            4'd6:    mag = 783;
            4'd7:    mag = 399;
            default: mag = 0;
        endcase
        if (cu == 3'd0) begin
            mag = 1448;
            neg = 1'b0;
        end
        return COEF_W'(neg ? -mag : mag);
    endfunction

    function automatic logic [7:0] clip(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> 16;
        if (s < 0)
            return 8'd0;
        else if (s > 255)
            return 8'd255;
        else
            return s[7:0];
    endfunction

    // The data on T_read_data belongs to the address issued last cycle, i.e. row u-1
    // (after the increment past 7, u-1 wraps to 7 for the flush cycle).
    assign coef_c   = coef(u - 3'd1, x);
    assign prod     = $signed(bus.T_read_data) * coef_c;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset)
            state <= S_CS_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_CS_IDLE:  if (bus.CS_start) state_n = S_CS_READ;
            S_CS_READ:  if (u == 3'd7) state_n = S_CS_FLUSH;
            S_CS_FLUSH: state_n = S_CS_WRITE;
            S_CS_WRITE: state_n = (x == 3'd7 && y == 3'd7) ? S_CS_DONE : S_CS_READ;
            S_CS_DONE:  state_n = S_CS_IDLE;
            default:    state_n = S_CS_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            x                <= '0;
            y                <= '0;
            u                <= '0;
            acc              <= '0;
            bus.T_address    <= '0;
            bus.S_address    <= '0;
            bus.S_write_data <= '0;
            bus.S_we         <= 1'b0;
            bus.CS_done      <= 1'b0;
        end else begin
            bus.S_we    <= 1'b0;
            bus.CS_done <= 1'b0;
            case (state)
                S_CS_IDLE: begin
                    if (bus.CS_start) begin
                        x   <= '0;
                        y   <= '0;
                        u   <= '0;
                        acc <= '0;
                    end
                end
                S_CS_READ: begin
                    bus.T_address <= {u, y};
                    u             <= u + 3'd1;
                    if (u != 3'd0)
                        acc <= acc + prod_ext;
                end
                S_CS_FLUSH: begin
                    acc <= acc + prod_ext;
                end
                S_CS_WRITE: begin
                    bus.S_we         <= 1'b1;
                    bus.S_address    <= S_BASE + {3'b000, x, y};
                    bus.S_write_data <= clip(acc);
                    acc              <= '0;
                    y                <= y + 3'd1;
                    if (y == 3'd7)
                        x <= x + 3'd1;
                end
                S_CS_DONE: begin
                    bus.CS_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compute_s.sv
// Scoreboard bench for compute_s: drivers queue the expected S RAM writes,
// a negedge monitor checks address, data and write cycle of every S_we.
module tb_compute_s;

    localparam logic [8:0] BASE = 9'd480;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    compute_s_if ifc ();

    compute_s #(.S_BASE(BASE)) dut (
        .CLOCK_50_I (clk),
        .Reset      (rst),
        .bus        (ifc)
    );

    logic signed [31:0] tmem [64];
    assign ifc.T_read_data = tmem[ifc.T_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   expv[64];

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ifc.S_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                check("s_address", int'(ifc.S_address), e.addr);
                check("s_write_data", int'(ifc.S_write_data), e.data);
                check("s_write_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic int coef_ref(input int u, input int x);
        real a;
        real cv;
        int  mag;
        if (u == 0) return 1448;
        a   = 3.14159265358979 * real'((2 * x + 1) * u) / 16.0;
        cv  = $cos(a);
        mag = $rtoi(2048.0 * ((cv < 0.0) ? -cv : cv));
        return (cv < 0.0) ? -mag : mag;
    endfunction

    function automatic int clip_ref(input longint v);
        longint s;
        s = v >>> 16;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return int'(s);
    endfunction

    task automatic clear_t();
        for (int i = 0; i < 64; i++) tmem[i] = 32'sd0;
    endtask

    task automatic fill_row0(input logic signed [31:0] v);
        clear_t();
        for (int yy = 0; yy < 8; yy++) tmem[yy] = v;
    endtask

    task automatic set_expv_all(input int v);
        for (int i = 0; i < 64; i++) expv[i] = v;
    endtask

    task automatic push_block(input int sc);
        exp_t e;
        for (int n = 0; n < 64; n++) begin
            e.addr = (int'(BASE) + n) % 512;
            e.data = expv[n];
            e.cyc  = sc + 10 * n + 10;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name, input int sc, input int remaining);
        int t;
        t = 0;
        while (ifc.CS_done !== 1'b1 && t < 700) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done_cycle"}, cyc, sc + 641);
        check({name, "_writes_left"}, sb.size(), remaining);
        @(negedge clk);
        check({name, "_done_pulse_end"}, int'(ifc.CS_done), 0);
    endtask

    task automatic run_block(input string name);
        int sc;
        @(negedge clk);
        sc = cyc + 1;
        push_block(sc);
        ifc.CS_start = 1'b1;
        @(negedge clk);
        ifc.CS_start = 1'b0;
        wait_done(name, sc, 0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_T_address"}, int'(ifc.T_address), 0);
        check({name, "_S_address"}, int'(ifc.S_address), 0);
        check({name, "_S_write_data"}, int'(ifc.S_write_data), 0);
        check({name, "_S_we"}, int'(ifc.S_we), 0);
        check({name, "_CS_done"}, int'(ifc.CS_done), 0);
    endtask

    initial begin
        int sc;
        int act;
        int col0[8];
        col0 = '{251, 212, 142, 49, 0, 0, 0, 0};

        rst          = 1'b1;
        ifc.CS_start = 1'b0;
        clear_t();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_expv_all(0);
        run_block("zero");

        fill_row0(32'sd4526);
        set_expv_all(100);
        run_block("dc100");

        fill_row0(32'sd46352);
        set_expv_all(255);
        run_block("clip_hi");

        fill_row0(-32'sd46352);
        set_expv_all(0);
        run_block("clip_lo");

        fill_row0(32'sh7FFF_FFFF);
        set_expv_all(255);
        run_block("max_pos");

        fill_row0(32'sh8000_0000);
        set_expv_all(0);
        run_block("max_neg");

        clear_t();
        tmem[8] = 32'sd8192;
        set_expv_all(0);
        for (int xx = 0; xx < 8; xx++) expv[xx * 8] = col0[xx];
        run_block("t10");

        clear_t();
        for (int uu = 0; uu < 8; uu++) tmem[uu * 8 + uu] = 32'sd8192;
        for (int xx = 0; xx < 8; xx++)
            for (int yy = 0; yy < 8; yy++)
                expv[xx * 8 + yy] = clip_ref(longint'(coef_ref(yy, xx)) * 64'sd8192);
        run_block("diag");

        // Abort at cycle 300: element 29's write edge is swallowed by the reset.
        fill_row0(32'sd4526);
        set_expv_all(100);
        @(negedge clk);
        sc = cyc + 1;
        push_block(sc);
        ifc.CS_start = 1'b1;
        @(negedge clk);
        ifc.CS_start = 1'b0;
        while (cyc < sc + 299) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_writes_left", sb.size(), 35);
        sb.delete();
        check_idle_outputs("abort");
        act = 0;
        repeat (400) begin
            @(negedge clk);
            if (ifc.S_we !== 1'b0 || ifc.CS_done !== 1'b0) act++;
        end
        check("abort_quiet", act, 0);
        run_block("restart");

        @(negedge clk);
        rst          = 1'b1;
        ifc.CS_start = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        ifc.CS_start = 1'b0;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.S_we !== 1'b0 || ifc.CS_done !== 1'b0 || ifc.T_address !== 6'd0) act++;
        end
        check("reset_beats_start", act, 0);

        // Start held high: the second block may only begin at cycle 642.
        @(negedge clk);
        sc = cyc + 1;
        push_block(sc);
        push_block(sc + 642);
        ifc.CS_start = 1'b1;
        @(negedge clk);
        wait_done("held1", sc, 64);
        ifc.CS_start = 1'b0;
        wait_done("held2", sc + 642, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
